// File: rtl/sram_rw_port_ctrl.sv
// sram_rw_port_ctrl: arbitrates read/write request streams onto a 1-cycle-latency single-port SRAM
// and returns read data through a credit-controlled response FIFO.
// Optional perf counters: define SRAM_RW_CTRL_PERF_EN.
module sram_rw_port_ctrl #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 256,
    parameter int MASK_W     = 32,
    parameter int RESP_DEPTH = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [ADDR_W-1:0] rd_req_addr,
    input  logic              wr_req_valid,
    output logic              wr_req_ready,
    input  logic [ADDR_W-1:0] wr_req_addr,
    input  logic [MASK_W-1:0] wr_req_mask,
    input  logic [DATA_W-1:0] wr_req_data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic [ADDR_W-1:0] RW0_addr,
    output logic              RW0_en,
    output logic              RW0_wmode,
    output logic [MASK_W-1:0] RW0_wmask,
    output logic [DATA_W-1:0] RW0_wdata,
    input  logic [DATA_W-1:0] RW0_rdata
`ifdef SRAM_RW_CTRL_PERF_EN
    ,
    output logic [31:0]       perf_rd_cnt,
    output logic [31:0]       perf_wr_cnt,
    output logic [31:0]       perf_conflict_cnt
`endif
);
    localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CW = $clog2(RESP_DEPTH + 1) + 1;

    logic [CW-1:0]     r_count;
    logic              r_inflight;
    logic              r_rr_last;
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [DATA_W-1:0] r_fifo [RESP_DEPTH];

    logic              w_pop;
    logic [CW-1:0]     w_occ;
    logic              w_read_ok;
    logic              w_conflict;
    logic              w_gnt_rd;
    logic              w_gnt_wr;

    // Credit check, round-robin arbitration (r_rr_last=1 means write won last, so read wins next) and SRAM drive
    always_comb begin
        resp_valid   = r_count != '0;
        resp_data    = r_fifo[r_rptr];
        w_pop        = resp_valid && resp_ready;
        w_occ        = r_count + CW'(r_inflight) - CW'(w_pop);
        w_read_ok    = w_occ < CW'(RESP_DEPTH);
        w_conflict   = !reset && rd_req_valid && wr_req_valid && w_read_ok;
        w_gnt_rd     = !reset && rd_req_valid && w_read_ok && (!wr_req_valid || r_rr_last);
        w_gnt_wr     = !reset && wr_req_valid && !w_gnt_rd;
        rd_req_ready = w_gnt_rd;
        wr_req_ready = w_gnt_wr;
        RW0_en       = w_gnt_rd || w_gnt_wr;
        RW0_wmode    = w_gnt_wr;
        RW0_addr     = w_gnt_wr ? wr_req_addr : rd_req_addr;
        RW0_wmask    = w_gnt_wr ? wr_req_mask : '0;
        RW0_wdata    = wr_req_data;
    end

    // Read pipeline state: in-flight flag, FIFO occupancy/pointers and arbitration history
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count    <= '0;
            r_inflight <= 1'b0;
            r_rr_last  <= 1'b1;
            r_wptr     <= '0;
            r_rptr     <= '0;
        end else begin
            r_count    <= w_occ;
            r_inflight <= w_gnt_rd;
            if (w_conflict) r_rr_last <= w_gnt_wr;
            if (r_inflight) r_wptr <= (r_wptr == PW'(RESP_DEPTH - 1)) ? '0 : r_wptr + 1'b1;
            if (w_pop) r_rptr <= (r_rptr == PW'(RESP_DEPTH - 1)) ? '0 : r_rptr + 1'b1;
        end
    end

    // Capture SRAM read data in the cycle after the read issue
    always_ff @(posedge clock) begin
        if (r_inflight) r_fifo[r_wptr] <= RW0_rdata;
    end

    // The credit check guarantees the FIFO never overflows
    assert property (@(posedge clock) disable iff (reset) r_count <= CW'(RESP_DEPTH));

`ifdef SRAM_RW_CTRL_PERF_EN
    // Saturating accept and conflict counters
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_rd_cnt       <= '0;
            perf_wr_cnt       <= '0;
            perf_conflict_cnt <= '0;
        end else begin
            if (w_gnt_rd && perf_rd_cnt != '1) perf_rd_cnt <= perf_rd_cnt + 1'b1;
            if (w_gnt_wr && perf_wr_cnt != '1) perf_wr_cnt <= perf_wr_cnt + 1'b1;
            if (w_conflict && perf_conflict_cnt != '1) perf_conflict_cnt <= perf_conflict_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_sram_rw_port_ctrl.sv
// tb_sram_rw_port_ctrl: scoreboard bench for sram_rw_port_ctrl with a behavioural SRAM macro.
module tb_sram_rw_port_ctrl;
    localparam int AW = 8, DW = 256, MW = 32, LW = DW / MW;

    logic          clock = 1'b0, reset = 1'b1;
    logic          rd_req_valid = 0, rd_req_ready, wr_req_valid = 0, wr_req_ready;
    logic [AW-1:0] rd_req_addr = '0, wr_req_addr = '0, RW0_addr;
    logic [MW-1:0] wr_req_mask = '0, RW0_wmask;
    logic [DW-1:0] wr_req_data = '0, resp_data, RW0_wdata, RW0_rdata;
    logic          resp_valid, resp_ready = 1'b1, RW0_en, RW0_wmode;
`ifdef SRAM_RW_CTRL_PERF_EN
    logic [31:0]   perf_rd_cnt, perf_wr_cnt, perf_conflict_cnt;
`endif

    sram_rw_port_ctrl #(.ADDR_W(AW), .DATA_W(DW), .MASK_W(MW), .RESP_DEPTH(2)) dut (
        .clock(clock), .reset(reset),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
        .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready), .wr_req_addr(wr_req_addr),
        .wr_req_mask(wr_req_mask), .wr_req_data(wr_req_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .RW0_addr(RW0_addr), .RW0_en(RW0_en), .RW0_wmode(RW0_wmode), .RW0_wmask(RW0_wmask),
        .RW0_wdata(RW0_wdata), .RW0_rdata(RW0_rdata)
`ifdef SRAM_RW_CTRL_PERF_EN
        , .perf_rd_cnt(perf_rd_cnt), .perf_wr_cnt(perf_wr_cnt), .perf_conflict_cnt(perf_conflict_cnt)
`endif
    );

    always #5 clock = ~clock;

    logic [DW-1:0] sram [256];
    logic [DW-1:0] exp_mem [256];
    logic [DW-1:0] sb [$];

    // Behavioural 1-cycle-latency SRAM macro
    always @(posedge clock) begin
        if (RW0_en && RW0_wmode) begin
            for (int l = 0; l < MW; l++) if (RW0_wmask[l]) sram[RW0_addr][l*LW +: LW] <= RW0_wdata[l*LW +: LW];
        end else if (RW0_en) RW0_rdata <= sram[RW0_addr];
    end

    int n_chk = 0, n_fail = 0, cyc = 0;
    int n_pops = 0, first_pop = -1, last_pop = -1;
    logic s_rd_rdy, s_wr_rdy, s_en, s_wmode, s_rv;
    logic [DW-1:0] s_rdata, last_data;

    function automatic logic [DW-1:0] pat(int i);
        logic [7:0] b;
        b = 8'(i);
        return {8{b, 8'h11, 8'h22, 8'h33}};
    endfunction

    // One clock: sample at negedge, score responses and accepts, advance past posedge
    task automatic step();
        logic [DW-1:0] e;
        @(negedge clock);
        s_rd_rdy = rd_req_ready; s_wr_rdy = wr_req_ready; s_en = RW0_en; s_wmode = RW0_wmode;
        s_rv = resp_valid; s_rdata = resp_data;
        if (resp_valid && resp_ready) begin
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++; $display("FAIL resp_unexpected: got %h required no response", resp_data);
            end else begin
                e = sb.pop_front();
                if (resp_data !== e) begin n_fail++; $display("FAIL resp_data: got %h required %h", resp_data, e); end
            end
            last_data = resp_data; n_pops++;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
        end
        if (wr_req_valid && wr_req_ready)
            for (int l = 0; l < MW; l++) if (wr_req_mask[l]) exp_mem[wr_req_addr][l*LW +: LW] = wr_req_data[l*LW +: LW];
        if (rd_req_valid && rd_req_ready) sb.push_back(exp_mem[rd_req_addr]);
        @(posedge clock); #1; cyc++;
    endtask

    task automatic drain();
        rd_req_valid = 0; wr_req_valid = 0; resp_ready = 1;
        for (int i = 0; i < 20 && (sb.size() != 0 || resp_valid); i++) step();
        n_chk++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL drain_timeout: got %0d pending required 0", sb.size()); end
    endtask

    task automatic test_reset();
        rd_req_valid = 1; wr_req_valid = 1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_chk += 5;
            if (s_rd_rdy !== 0) begin n_fail++; $display("FAIL reset_rd_ready: got %b required 0", s_rd_rdy); end
            if (s_wr_rdy !== 0) begin n_fail++; $display("FAIL reset_wr_ready: got %b required 0", s_wr_rdy); end
            if (s_rv !== 0) begin n_fail++; $display("FAIL reset_resp_valid: got %b required 0", s_rv); end
            if (s_en !== 0) begin n_fail++; $display("FAIL reset_en: got %b required 0", s_en); end
            if (s_wmode !== 0) begin n_fail++; $display("FAIL reset_wmode: got %b required 0", s_wmode); end
        end
        rd_req_valid = 0; wr_req_valid = 0; reset = 0;
        step();
    endtask

    task automatic test_write_read();
        wr_req_valid = 1; wr_req_addr = 8'h10; wr_req_mask = '1; wr_req_data = {32{8'hA5}};
        step();
        n_chk += 2;
        if ({s_wr_rdy, s_en, s_wmode} !== 3'b111) begin n_fail++; $display("FAIL wr_issue: got %b required 111", {s_wr_rdy, s_en, s_wmode}); end
        wr_req_valid = 0; rd_req_valid = 1; rd_req_addr = 8'h10;
        step();
        if ({s_rd_rdy, s_en, s_wmode} !== 3'b110) begin n_fail++; $display("FAIL rd_issue: got %b required 110", {s_rd_rdy, s_en, s_wmode}); end
        rd_req_valid = 0;
        step();
        n_chk++;
        if (s_rv !== 0) begin n_fail++; $display("FAIL resp_early: got %b required 0", s_rv); end
        step();
        n_chk += 2;
        if (s_rv !== 1) begin n_fail++; $display("FAIL resp_latency: got %b required 1", s_rv); end
        if (s_rdata !== {32{8'hA5}}) begin n_fail++; $display("FAIL raw_data: got %h required %h", s_rdata, {32{8'hA5}}); end
        drain();
    endtask

    task automatic test_back_to_back();
        n_pops = 0; first_pop = -1; last_pop = -1;
        rd_req_valid = 1;
        for (int i = 0; i < 8; i++) begin
            rd_req_addr = 8'(i);
            step();
            n_chk++;
            if (s_rd_rdy !== 1) begin n_fail++; $display("FAIL b2b_ready_%0d: got %b required 1", i, s_rd_rdy); end
        end
        drain();
        n_chk += 2;
        if (n_pops != 8) begin n_fail++; $display("FAIL b2b_count: got %0d required 8", n_pops); end
        if (last_pop - first_pop != 7) begin n_fail++; $display("FAIL b2b_spacing: got %0d required 7", last_pop - first_pop); end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        resp_ready = 0; rd_req_valid = 1; rd_req_addr = 8'd20;
        for (int i = 0; i < 6; i++) begin
            step();
            if (s_rd_rdy) begin acc++; rd_req_addr = 8'(20 + acc); end
        end
        n_chk += 2;
        if (acc != 2) begin n_fail++; $display("FAIL bp_accepts: got %0d required 2", acc); end
        if (s_rd_rdy !== 0) begin n_fail++; $display("FAIL bp_ready: got %b required 0", s_rd_rdy); end
        resp_ready = 1;
        for (int i = 0; i < 20 && acc < 5; i++) begin
            step();
            if (s_rd_rdy) begin acc++; rd_req_addr = 8'(20 + acc); end
        end
        n_chk++;
        if (acc != 5) begin n_fail++; $display("FAIL bp_resume: got %0d required 5", acc); end
        drain();
    endtask

    task automatic test_conflict();
`ifdef SRAM_RW_CTRL_PERF_EN
        logic [31:0] p_rd = perf_rd_cnt, p_wr = perf_wr_cnt, p_cf = perf_conflict_cnt;
`endif
        rd_req_valid = 1; rd_req_addr = 8'h50;
        wr_req_valid = 1; wr_req_addr = 8'h60; wr_req_mask = '1; wr_req_data = pat(99);
        for (int i = 0; i < 4; i++) begin
            step();
            n_chk += 2;
            if (s_rd_rdy !== (i % 2 == 0)) begin n_fail++; $display("FAIL conflict_rd_%0d: got %b required %b", i, s_rd_rdy, i % 2 == 0); end
            if (s_wr_rdy !== (i % 2 == 1)) begin n_fail++; $display("FAIL conflict_wr_%0d: got %b required %b", i, s_wr_rdy, i % 2 == 1); end
        end
        drain();
`ifdef SRAM_RW_CTRL_PERF_EN
        n_chk += 3;
        if (perf_rd_cnt - p_rd != 2) begin n_fail++; $display("FAIL perf_rd: got %0d required 2", perf_rd_cnt - p_rd); end
        if (perf_wr_cnt - p_wr != 2) begin n_fail++; $display("FAIL perf_wr: got %0d required 2", perf_wr_cnt - p_wr); end
        if (perf_conflict_cnt - p_cf != 4) begin n_fail++; $display("FAIL perf_conflict: got %0d required 4", perf_conflict_cnt - p_cf); end
`endif
    endtask

    task automatic test_partial_mask();
        logic [DW-1:0] want = {{31{8'h3C}}, 8'hFF};
        wr_req_valid = 1; wr_req_addr = 8'h30; wr_req_mask = '1; wr_req_data = {32{8'h3C}};
        step();
        wr_req_mask = 32'h1; wr_req_data = 256'hFF;
        step();
        wr_req_valid = 0; rd_req_valid = 1; rd_req_addr = 8'h30;
        step();
        drain();
        n_chk++;
        if (last_data !== want) begin n_fail++; $display("FAIL partial_mask: got %h required %h", last_data, want); end
    endtask

    task automatic test_reset_mid();
        rd_req_valid = 1; rd_req_addr = 8'h07;
        step();
        reset = 1; sb.delete();
        wr_req_valid = 1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_chk += 4;
            if (s_rd_rdy !== 0) begin n_fail++; $display("FAIL rst_rd_ready: got %b required 0", s_rd_rdy); end
            if (s_wr_rdy !== 0) begin n_fail++; $display("FAIL rst_wr_ready: got %b required 0", s_wr_rdy); end
            if (s_rv !== 0) begin n_fail++; $display("FAIL rst_resp_valid: got %b required 0", s_rv); end
            if (s_en !== 0) begin n_fail++; $display("FAIL rst_en: got %b required 0", s_en); end
        end
        reset = 0; rd_req_valid = 0; wr_req_valid = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_chk++;
            if (s_rv !== 0) begin n_fail++; $display("FAIL rst_discard_%0d: got %b required 0", i, s_rv); end
        end
        rd_req_valid = 1; rd_req_addr = 8'h10;
        step();
        drain();
        n_chk++;
        if (last_data !== {32{8'hA5}}) begin n_fail++; $display("FAIL rst_contents: got %h required %h", last_data, {32{8'hA5}}); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin sram[i] = pat(i); exp_mem[i] = pat(i); end
        test_reset();
        test_write_read();
        test_back_to_back();
        test_backpressure();
        test_conflict();
        test_partial_mask();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
